// File: rtl/ddr_deser_pkg.sv
// Shared types and constants for the DDR word deserializer.
package ddr_deser_pkg;

    // Alignment state: hunting for the sync word, or locked to word boundaries.
    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Default alignment pattern for the 8-bit configuration.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Width of the optional dropped-word counter.
    localparam int OVF_CNT_W = 8;

endpackage

// File: rtl/ddr_pair_capture.sv
// Dual-edge capture front end: holds the bit sampled on the falling edge and
// presents it together with the live line value to the rising-edge logic.
// The older (falling-edge) bit sits in the upper position of the pair.
module ddr_pair_capture (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_din,
    output logic [1:0] o_pair
);

    logic r_neg_bit;

    // Capture the line on every falling edge, whatever the enable state.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_bit <= 1'b0;
        end else begin
            r_neg_bit <= i_din;
        end
    end

    assign o_pair = {r_neg_bit, i_din};

endmodule

// File: rtl/ddr_word_deser.sv
// DDR word deserializer: collects two bits per clock period, aligns to a sync
// word on 2-bit boundaries, then assembles W-bit words into a valid/ready
// output register.
// Optional feature: define DDR_WORD_DESER_OVF_CNT_EN to add the ovf_cnt port,
// a saturating count of dropped words.
module ddr_word_deser
    import ddr_deser_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   SYNC = W'(SYNC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 en,
    input  logic                 resync,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 overflow
`ifdef DDR_WORD_DESER_OVF_CNT_EN
   ,output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

    localparam int              PAIRS    = W / 2;
    localparam int              CNT_W    = $clog2(PAIRS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);

    // Reject widths the pair-based assembly cannot handle.
    if ((W % 2) != 0 || W < 4) begin : g_bad_width
        $error("ddr_word_deser: W must be even and at least 4");
    end

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [W-1:0]     r_sr;
    logic [W-1:0]     w_sr_next;
    logic [1:0]       w_pair;
    logic             w_complete;
    logic             w_drop;
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;
    logic             r_overflow;

    ddr_pair_capture u_pair_capture (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (din),
        .o_pair (w_pair)
    );

    // Older bit above newer bit; the earliest bit ends up at the MSB.
    assign w_sr_next = {r_sr[W-3:0], w_pair};

    // Shift register advances only on enabled edges, including a resync edge.
    // NOTE: clocked state uses non-blocking assignments so every register in
    // the design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (en) begin
            r_sr <= w_sr_next;
        end
    end

    // State and pair-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, counter and word completion; resync overrides everything.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_complete   = 1'b0;
        if (resync) begin
            w_state_next = HUNT;
            w_cnt_next   = '0;
        end else if (en) begin
            case (r_state)
                HUNT: begin
                    if (w_sr_next == SYNC) begin
                        w_state_next = LOCK;
                        w_cnt_next   = '0;
                    end
                end
                LOCK: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
                        w_complete = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = HUNT;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // A completed word is dropped when the previous one is still unaccepted.
    assign w_drop = w_complete & r_out_valid & ~out_ready;

    // Output register: load on completion when there is room, clear valid on
    // an accept with nothing new to load; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            if (!r_out_valid || out_ready) begin
                r_out_data  <= w_sr_next;
                r_out_valid <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky drop flag, cleared by realignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (resync) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef DDR_WORD_DESER_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    // Saturating count of dropped words, cleared by realignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (resync) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign locked    = (r_state == LOCK);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ddr_word_deser.sv
// Self-checking bench for ddr_word_deser (W=8, SYNC=A5): directed scenarios
// with literal expectations plus randomized traffic, all compared every cycle
// against a bit-stream model kept in the bench.
module tb_ddr_word_deser;

    localparam int         W     = 8;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         din;
    logic         en;
    logic         resync;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         locked;
    logic         overflow;
`ifdef DDR_WORD_DESER_OVF_CNT_EN
    logic [7:0]   ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ddr_word_deser #(.W(W), .SYNC(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .en        (en),
        .resync    (resync),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
        .overflow  (overflow)
`ifdef DDR_WORD_DESER_OVF_CNT_EN
       ,.ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model keeps the recent enabled bit stream as a queue; while locked it
    // counts pairs since the last word boundary and takes the newest W bits as
    // the word once W/2 pairs have arrived.
    bit         m_q[$];
    bit         m_neg;
    int         m_pairs;
    bit         m_locked;
    bit         m_valid;
    bit         m_ovf;
    logic [7:0] m_data;
    int         m_ovfcnt;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(1'b0);
        m_neg    = 1'b0;
        m_pairs  = 0;
        m_locked = 1'b0;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
        m_data   = '0;
        m_ovfcnt = 0;
    endtask

    function automatic logic [W-1:0] m_window();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = m_q[m_q.size() - 1 - i];
        return r;
    endfunction

    always @(negedge clk) m_neg = rst_n ? din : 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            bit           accept;
            bit           done;
            logic [W-1:0] cand;
            accept = m_valid && out_ready;
            done   = 1'b0;
            cand   = '0;
            if (en) begin
                m_q.push_back(m_neg);
                m_q.push_back(din);
                void'(m_q.pop_front());
                void'(m_q.pop_front());
            end
            if (resync) begin
                m_locked = 1'b0;
                m_pairs  = 0;
                m_ovf    = 1'b0;
                m_ovfcnt = 0;
            end else if (en) begin
                if (!m_locked) begin
                    if (m_window() == SYNC) begin
                        m_locked = 1'b1;
                        m_pairs  = 0;
                    end
                end else begin
                    m_pairs++;
                    if (m_pairs == W / 2) begin
                        done    = 1'b1;
                        cand    = m_window();
                        m_pairs = 0;
                    end
                end
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_data  = cand;
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_ovfcnt < 255) m_ovfcnt++;
                end
            end else if (accept) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_data",  32'(out_data),  32'(m_data));
            check("locked",    32'(locked),    32'(m_locked));
            check("overflow",  32'(overflow),  32'(m_ovf));
`ifdef DDR_WORD_DESER_OVF_CNT_EN
            check("ovf_cnt",   32'(ovf_cnt),   32'(m_ovfcnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; presents the older bit for the falling
    // edge, then the newer bit for the next rising edge, and returns just after it.
    task automatic drive_pair(input bit b_old, input bit b_new, input bit e,
                              input bit rs, input bit rdy);
        din       = b_old;
        en        = e;
        resync    = rs;
        out_ready = rdy;
        @(negedge clk);
        #1 din = b_new;
        @(posedge clk);
        #1;
        resync = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rdy);
        for (int i = W / 2 - 1; i >= 0; i--) drive_pair(b[2*i+1], b[2*i], 1'b1, 1'b0, rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        din = 1'b0; en = 1'b0; resync = 1'b0; out_ready = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid",  32'(out_valid), 32'd0);
        check("reset_locked", 32'(locked),    32'd0);
        rst_n = 1'b1;

        // Align and deliver: A5, 3C, 96.
        send_byte(8'hA5, 1'b1);
        check("lock_on_sync", 32'(locked), 32'd1);
        check("sync_not_out", 32'(out_valid), 32'd0);
        send_byte(8'h3C, 1'b1);
        check("word1_valid", 32'(out_valid), 32'd1);
        check("word1_data",  32'(out_data),  32'h3C);
        send_byte(8'h96, 1'b1);
        check("word2_data",  32'(out_data),  32'h96);

        // Reset mid-stream while a word is pending.
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_data",   32'(out_data),  32'd0);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_locked", 32'(locked),    32'd0);
        check("rst_ovf",    32'(overflow),  32'd0);
        en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'hA5, 1'b1);
        check("relock_after_rst", 32'(locked), 32'd1);
        send_byte(8'h5A, 1'b1);
        check("post_rst_word", 32'(out_data), 32'h5A);

        // Odd-offset sync is never found.
        drive_pair(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (4) drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drive_pair(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("odd_no_lock",  32'(locked),    32'd0);
        check("odd_no_valid", 32'(out_valid), 32'd0);

        // Backpressure across two completed words.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("bp_data_held", 32'(out_data), 32'h11);
        check("bp_overflow",  32'(overflow), 32'd1);
`ifdef DDR_WORD_DESER_OVF_CNT_EN
        check("bp_ovf_cnt",   32'(ovf_cnt),  32'd1);
`endif

        // Ready only on the completion edge: replacement without a drop.
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("swap_data",  32'(out_data),  32'h33);
        check("swap_valid", 32'(out_valid), 32'd1);

        // Stall for three cycles mid-word (word 4C).
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) drive_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        check("stall_no_word", 32'(out_valid), 32'd0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stall_word", 32'(out_data), 32'h4C);

        // Resync on a completion edge discards that word (77).
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_pair(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rs_locked",  32'(locked),    32'd0);
        check("rs_ovf_clr", 32'(overflow),  32'd0);
        check("rs_kept",    32'(out_data),  32'h4C);
        check("rs_valid",   32'(out_valid), 32'd1);
        send_byte(8'hA5, 1'b1);
        check("rs_relock", 32'(locked), 32'd1);
        send_byte(8'h99, 1'b1);
        check("rs_next_word", 32'(out_data), 32'h99);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0)
                drive_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
            if ($urandom_range(0, 3) != 0) send_byte(SYNC, 1'($urandom_range(0, 1)));
            for (int j = 0; j < 4 * int'($urandom_range(1, 5)); j++) begin
                drive_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 5) != 0, $urandom_range(0, 39) == 0,
                           $urandom_range(0, 2) != 0);
            end
        end

        @(posedge clk);
        #1 chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
